cache_plru_store: RTL and testbench
===================================

Name: cache_plru_store

Overview:
- Per-set PLRU state store; the stateful partner of the combinational replacement logic. Holds the 7-bit (WAYS-1) tree-PLRU vector for every set.
- For each access it presents the set's current PLRU bits, hit flag and hit way to the replacement logic.
- It writes the returned updated bits back and reports the selected way (victim on miss, hit way on hit) to the cache controller.
- Sits between the cache controller's lookup path and the replacement logic. Includes an initialisation sweep and back-to-back same-set forwarding.

Parameters:
- SETS, 16384, number of cache sets.
- SET_BITS, 14, index width; equals log2(SETS).
- WAYS, 8, associativity.
- WAYS_REP, 3, way encoding width; equals log2(WAYS).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr_all  in  1  one-cycle pulse; restarts the init sweep.
- req_valid  in  1  access request valid.
- req_ready  out  1  store can accept a request.
- req_set  in  SET_BITS  set index.
- req_hit  in  1  access hit.
- req_way  in  WAYS_REP  hit way; don't-care on a miss.
- plru_cur  out  WAYS-1  stage-1 PLRU bits sent to the replacement logic.
- rep_hit  out  1  stage-1 hit flag sent to the replacement logic.
- rep_way_hit  out  WAYS_REP  stage-1 hit way sent to the replacement logic.
- plru_next  in  WAYS-1  updated bits returned by the replacement logic (combinational).
- rep_way  in  WAYS_REP  selected way returned by the replacement logic.
- rsp_valid  out  1  response valid.
- rsp_set  out  SET_BITS  set index of the response.
- rsp_way  out  WAYS_REP  selected way.
- rsp_hit  out  1  echo of the request's hit flag.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to INIT and the sweep pointer goes to 0.
  - Stage-1 valid goes to 0.
  - rsp_valid, rsp_set, rsp_way, rsp_hit all go to 0; req_ready goes to 0.
  - Array contents are not cleared by reset itself; the sweep clears them.
- FSM:
  - INIT: writes array[ptr]=0 each cycle and increments ptr. req_ready=0. When ptr==SETS-1 is written, go to RUN next cycle.
  - RUN: req_ready=1.
  - clr_all in RUN: go to INIT with ptr=0. Any request in stage 1 that cycle still completes, with its write-back and response. A request presented in the same cycle as clr_all is not accepted; req_ready=0 combinationally when clr_all=1.
  - clr_all in INIT: restarts ptr at 0.
  - Reset asserted mid-sweep or mid-request: the pending stage-1 request is dropped and no response is issued.
- Pipeline (handshake = req_valid & req_ready at edge N):
  - Edge N: stage 1 captures set, hit and way, plus PLRU bits read from array[req_set], or the forwarded value (see below).
  - Cycle N to N+1: stage 1 drives plru_cur, rep_hit and rep_way_hit.
  - Edge N+1: array[set] is written with plru_next. rsp_valid=1 and rsp_set/rsp_way/rsp_hit are registered from stage 1 and rep_way.
  - Latency is 1 cycle from acceptance to rsp_valid.
  - Throughput is 1 request per cycle; there is no response backpressure.
  - rsp_valid deasserts the cycle after a response with no new request; rsp_* payload holds its last value.
- Forwarding: if a request is accepted at edge N+1 while stage 1 holds the same set, stage 1 captures plru_next rather than the stale array value. A different set reads the array normally.
- Width rules:
  - req_set is used unmodified.
  - ptr is SET_BITS wide and wraps naturally. The terminal check uses ptr==SETS-1, so a non-power-of-2 SETS also works.
- Sweep-completion edge:
  - The first request can be accepted on the edge after the last sweep write.
  - plru_cur for any set after init is 0.

Optional Feature:
- Macro PLRU_STORE_STATS_EN.
- Defined: adds outputs stat_hits and stat_misses, each 32-bit saturating. They count responses by rsp_hit, are cleared by reset and clr_all, and hold at 0xFFFFFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared cache package: SETS, SET_BITS, WAYS, WAYS_REP constants; typedef plru_t (logic [WAYS-1-1:0]); typedef way_t; typedef set_t; enum plru_store_state_t {INIT, RUN}.
- One natural sub-module: cache_plru_array, a single-write-port, single-read-port PLRU storage with write-first bypass. The FSM and pipeline stay in the top module.

Test Plan:
- Reset then idle with SETS=16 → req_ready=0 for 16 cycles, then 1; a read of every set gives plru_cur=7'b0000000.
- Miss to set 3 after init, with a replacement-logic model attached → rsp_valid one cycle after acceptance with rsp_way=0. A second miss to set 3 gives rsp_way=4, matching the model's tree PLRU.
- Back-to-back accepts to set 5 (miss, miss, hit way 2) → the second and third see forwarded bits. rsp_way sequence is 0, 4, 2; the array finally holds the model's expected vector.
- Interleaved sets 1, 2, 1 → no cross-set forwarding; each set evolves independently per the model.
- clr_all while a request is in stage 1 → that response still issues. req_ready=0 for SETS cycles; afterwards all sets read 0.
- With PLRU_STORE_STATS_EN defined: 3 hits and 2 misses → stat_hits=3, stat_misses=2. clr_all → both 0.

Source files
------------

// File: rtl/cache_plru_store_pkg.sv
// Shared constants and types for the per-set tree-PLRU state store.
package cache_plru_store_pkg;

  localparam int unsigned SETS     = 16384;
  localparam int unsigned SET_BITS = 14;
  localparam int unsigned WAYS     = 8;
  localparam int unsigned WAYS_REP = 3;

  typedef logic [WAYS-1-1:0]   plru_t;
  typedef logic [WAYS_REP-1:0] way_t;
  typedef logic [SET_BITS-1:0] set_t;

  typedef enum logic {StInit, StRun} plru_store_state_t;

endpackage

// File: rtl/cache_plru_array.sv
// One-write/one-read PLRU storage; a same-cycle write to the read address is bypassed to the
// read data, which is what gives the top its back-to-back same-set forwarding.
module cache_plru_array import cache_plru_store_pkg::*; #(
  parameter int unsigned SETS     = cache_plru_store_pkg::SETS,
  parameter int unsigned SET_BITS = cache_plru_store_pkg::SET_BITS
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [SET_BITS-1:0] waddr_i,
  input  plru_t               wdata_i,
  input  logic [SET_BITS-1:0] raddr_i,
  output plru_t               rdata_o
);

  plru_t mem_q [SETS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) rdata_o = wdata_i;
  end

endmodule

// File: rtl/cache_plru_store.sv
// Per-set PLRU state store: init sweep FSM, one-stage lookup pipeline and write-back.
// Optional saturating hit/miss counters are enabled with `define PLRU_STORE_STATS_EN.
module cache_plru_store import cache_plru_store_pkg::*; #(
  parameter int unsigned SETS     = cache_plru_store_pkg::SETS,
  parameter int unsigned SET_BITS = cache_plru_store_pkg::SET_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_all,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_hit,
  input  way_t                req_way,
  output plru_t               plru_cur,
  output logic                rep_hit,
  output way_t                rep_way_hit,
  input  plru_t               plru_next,
  input  way_t                rep_way,
  output logic                rsp_valid,
  output logic [SET_BITS-1:0] rsp_set,
  output way_t                rsp_way,
`ifdef PLRU_STORE_STATS_EN
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
`endif
  output logic                rsp_hit
);

  localparam logic [SET_BITS-1:0] PtrLast = SET_BITS'(SETS - 1);

  plru_store_state_t   state_q, state_d;
  logic [SET_BITS-1:0] ptr_q, ptr_d;
  logic                s1_valid_q, s1_hit_q;
  logic [SET_BITS-1:0] s1_set_q;
  way_t                s1_way_q;
  plru_t               s1_plru_q;

  logic                accept, arr_we;
  logic [SET_BITS-1:0] arr_waddr;
  plru_t               arr_wdata, arr_rdata;

  assign req_ready   = (state_q == StRun) && !clr_all;
  assign accept      = req_valid && req_ready;
  assign plru_cur    = s1_plru_q;
  assign rep_hit     = s1_hit_q;
  assign rep_way_hit = s1_way_q;

  // Stage-1 write-back and the sweep never coincide: no request is accepted outside StRun.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = ptr_q;
    arr_wdata = '0;
    if (s1_valid_q) begin
      arr_we    = rst_n;
      arr_waddr = s1_set_q;
      arr_wdata = plru_next;
    end else if (state_q == StInit) begin
      arr_we = rst_n;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StInit: begin
        if (clr_all) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PtrLast) begin
            state_d = StRun;
            ptr_d   = '0;
          end
        end
      end
      StRun: begin
        if (clr_all) begin
          state_d = StInit;
          ptr_d   = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  cache_plru_array #(
    .SETS     (SETS),
    .SET_BITS (SET_BITS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (req_set),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_set_q   <= '0;
      s1_hit_q   <= 1'b0;
      s1_way_q   <= '0;
      s1_plru_q  <= '0;
      rsp_valid  <= 1'b0;
      rsp_set    <= '0;
      rsp_way    <= '0;
      rsp_hit    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_set_q  <= req_set;
        s1_hit_q  <= req_hit;
        s1_way_q  <= req_way;
        s1_plru_q <= arr_rdata;
      end
      rsp_valid <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_set <= s1_set_q;
        rsp_way <= rep_way;
        rsp_hit <= s1_hit_q;
      end
    end
  end

`ifdef PLRU_STORE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (clr_all) begin
      hits_d   = '0;
      misses_d = '0;
    end else if (s1_valid_q) begin
      if (s1_hit_q && (hits_q != '1))        hits_d   = hits_q + 32'd1;
      if (!s1_hit_q && (misses_q != '1))     misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_plru_store.sv
// Bench for cache_plru_store with SETS=16: attached tree-PLRU replacement model, vector table,
// hand sequences and randomized traffic against a per-set reference store.
module tb_cache_plru_store;
  import cache_plru_store_pkg::*;

  localparam int unsigned NS = 16;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst_n, clr_all, req_valid, req_ready, req_hit, rep_hit, rsp_valid, rsp_hit;
  logic [NB-1:0] req_set, rsp_set;
  way_t          req_way, rep_way_hit, rep_way, rsp_way;
  plru_t         plru_cur, plru_next;
`ifdef PLRU_STORE_STATS_EN
  logic [31:0]   stat_hits, stat_misses;
`endif

  cache_plru_store #(
    .SETS     (NS),
    .SET_BITS (NB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_all     (clr_all),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .req_hit     (req_hit),
    .req_way     (req_way),
    .plru_cur    (plru_cur),
    .rep_hit     (rep_hit),
    .rep_way_hit (rep_way_hit),
    .plru_next   (plru_next),
    .rep_way     (rep_way),
    .rsp_valid   (rsp_valid),
    .rsp_set     (rsp_set),
    .rsp_way     (rsp_way),
`ifdef PLRU_STORE_STATS_EN
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses),
`endif
    .rsp_hit     (rsp_hit)
  );

  always #5 clk = ~clk;

  // Tree PLRU: node n has children 2n+1 (bit 0, left) and 2n+2 (bit 1, right).
  // Victim follows the bits; an access sets each node on its path to point away from it.
  function automatic logic [9:0] rep_fn(input plru_t b, input logic hit, input way_t hw);
    int    n, d, w;
    plru_t nb;
    w = 0;
    if (hit) begin
      w = int'(hw);
    end else begin
      n = 0;
      for (int l = 0; l < 3; l++) begin
        d = int'(b[n]);
        w = w * 2 + d;
        n = 2 * n + 1 + d;
      end
    end
    nb = b;
    n  = 0;
    for (int l = 0; l < 3; l++) begin
      d     = (w >> (2 - l)) & 1;
      nb[n] = (d == 0);
      n     = 2 * n + 1 + d;
    end
    return {nb, way_t'(w)};
  endfunction

  always_comb {plru_next, rep_way} = rep_fn(plru_cur, rep_hit, rep_way_hit);

  // Reference store
  plru_t m_mem [NS];
  int    m_init;
  bit    m_s1_v, m_s1_hit, m_rsp_v, m_rsp_hit;
  int    m_s1_set, m_rsp_set;
  way_t  m_s1_way, m_rsp_way;
  plru_t m_s1_plru;
  longint m_hits, m_misses;

  int    tests = 0;
  int    fails = 0;
  plru_t last_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1_v = 0; m_rsp_v = 0; m_init = NS; m_hits = 0; m_misses = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
  endtask

  // Called just after a falling edge: drive, check combinational/stage-1, advance one clock.
  task automatic cycle(input bit v, input int s, input bit h, input way_t w, input bit c);
    bit          acc;
    logic [9:0]  r;
    req_valid = v; req_set = NB'(s); req_hit = h; req_way = w; clr_all = c;
    #1;
    chk("req_ready", 32'(req_ready), 32'(m_init == 0 && !c));
    acc = v && (m_init == 0) && !c;
    if (m_s1_v) begin
      chk("plru_cur", 32'(plru_cur), 32'(m_s1_plru));
      chk("rep_hit", 32'(rep_hit), 32'(m_s1_hit));
      chk("rep_way_hit", 32'(rep_way_hit), 32'(m_s1_way));
      last_cur  = plru_cur;
      r         = rep_fn(m_s1_plru, m_s1_hit, m_s1_way);
      m_mem[m_s1_set] = r[9:3];
      m_rsp_set = m_s1_set;
      m_rsp_way = r[2:0];
      m_rsp_hit = m_s1_hit;
      if (m_s1_hit) m_hits++; else m_misses++;
    end
    m_rsp_v = m_s1_v;
    if (c) begin
      m_init = NS;
      m_hits = 0;
      m_misses = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_init > 0) begin
      m_init--;
    end
    if (acc) begin
      m_s1_plru = m_mem[s];
      m_s1_set  = s;
      m_s1_hit  = h;
      m_s1_way  = w;
    end
    m_s1_v = acc;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) begin
      chk("rsp_set", 32'(rsp_set), 32'(m_rsp_set));
      chk("rsp_way", 32'(rsp_way), 32'(m_rsp_way));
      chk("rsp_hit", 32'(rsp_hit), 32'(m_rsp_hit));
    end
`ifdef PLRU_STORE_STATS_EN
    chk("stat_hits", stat_hits, 32'(m_hits));
    chk("stat_misses", stat_misses, 32'(m_misses));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr_all = 0; req_valid = 0; req_set = '0; req_hit = 0; req_way = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_set", 32'(rsp_set), 32'd0);
    chk("rst_rsp_way", 32'(rsp_way), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit   v;
    int   s;
    bit   h;
    way_t w;
    way_t exp_way;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 3, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0};
    tbl[2] = '{1, 3, 0, 0, 4};
    tbl[3] = '{1, 5, 0, 0, 0};
    tbl[4] = '{1, 5, 0, 0, 4};
    tbl[5] = '{1, 5, 1, 2, 2};
    tbl[6] = '{1, 1, 0, 0, 0};
    tbl[7] = '{1, 2, 0, 0, 0};
    tbl[8] = '{1, 1, 0, 0, 4};
    tbl[9] = '{0, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0);
    chk("ready_after_sweep", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].h, tbl[i].w, 0);
      if (i > 0 && tbl[i-1].v) chk("tbl_rsp_way", 32'(rsp_way), 32'(tbl[i-1].exp_way));
    end
    cycle(1, 5, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("set5_final", 32'(last_cur), 32'h3d);

    // clr_all with a request in stage 1: its response still issues
    cycle(1, 7, 0, 0, 0);
    cycle(1, 8, 0, 0, 1);
    chk("clr_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1, i, 0, 0, 0);
    for (int s = 0; s < 16; s++) begin
      cycle(1, s, 0, 0, 0);
      chk("swept_zero", 32'(plru_cur), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 1) == 1,
            way_t'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);

`ifdef PLRU_STORE_STATS_EN
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 2, 1, 3, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(1, 4, 1, 5, 0);
    cycle(0, 0, 0, 0, 0);
    chk("stat_hits_3", stat_hits, 32'd3);
    chk("stat_misses_2", stat_misses, 32'd2);
    cycle(0, 0, 0, 0, 1);
    chk("stat_hits_clr", stat_hits, 32'd0);
    chk("stat_misses_clr", stat_misses, 32'd0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0);
`endif

    // Reset with a request in stage 1 drops it
    cycle(1, 6, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0);
    chk("drop_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
